// File: rtl/mmu_pkg.sv
// Shared owner encodings and arbiter state type for the MMU page-table walk arbiter.
package mmu_pkg;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mmu_arb_pick.sv
// Combinational winner select between the I-MMU and D-MMU walk requests.
// Define MMU_ARB_RR_EN for round-robin on ties; otherwise D-MMU has fixed priority.
module mmu_arb_pick
  import mmu_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_owner,
  output logic o_win
);

`ifdef MMU_ARB_RR_EN
  always_comb begin
    o_win = OWN_I;
    if (i_req_i && i_req_d) begin
      // Tie goes to whoever was not served last.
      o_win = ~i_owner;
    end else if (i_req_d) begin
      o_win = OWN_D;
    end
  end
`else
  always_comb begin
    o_win = OWN_I;
    if (i_req_d) begin
      o_win = OWN_D;
    end
  end
`endif

endmodule

// File: rtl/mmu_walk_arbiter.sv
// Shares one page-table fetch port between the I-MMU and D-MMU; one walk read in flight at a time.
// Arbitration policy selected by MMU_ARB_RR_EN (see mmu_arb_pick).
module mmu_walk_arbiter
  import mmu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              suspend,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_ren,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_data,
  output logic              m_ren,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              owner
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_owner;
  logic              r_m_ren;
  logic [ADDR_W-1:0] r_m_addr;
  logic              r_i_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_i_data;
  logic [DATA_W-1:0] r_d_data;
  logic              w_win;
  logic              w_grant;
  logic              w_mem_done;

  mmu_arb_pick u_pick (
    .i_req_i (i_ren),
    .i_req_d (d_ren),
    .i_owner (r_owner),
    .o_win   (w_win)
  );

  assign w_grant    = (r_state == ST_IDLE) && !suspend && (i_ren || d_ren);
  assign w_mem_done = (r_state == ST_BUS) && m_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant)    w_state_nxt = ST_BUS;
      ST_BUS:  if (w_mem_done) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner  <= OWN_I;
      r_m_ren  <= 1'b0;
      r_m_addr <= '0;
      r_i_ack  <= 1'b0;
      r_d_ack  <= 1'b0;
      r_i_data <= '0;
      r_d_data <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (w_grant) begin
        r_owner  <= w_win;
        r_m_addr <= (w_win == OWN_D) ? d_addr : i_addr;
        r_m_ren  <= 1'b1;
      end
      if (w_mem_done) begin
        r_m_ren <= 1'b0;
        if (r_owner == OWN_D) begin
          r_d_data <= m_data;
        end else begin
          r_i_data <= m_data;
        end
      end
      // A requester that withdrew its ren before the response simply never sees an ack.
      if (r_state == ST_RESP) begin
        r_i_ack <= (r_owner == OWN_I) && i_ren;
        r_d_ack <= (r_owner == OWN_D) && d_ren;
      end
    end
  end

  assign i_ack  = r_i_ack;
  assign i_data = r_i_data;
  assign d_ack  = r_d_ack;
  assign d_data = r_d_data;
  assign m_ren  = r_m_ren;
  assign m_addr = r_m_addr;
  assign busy   = (r_state != ST_IDLE);
  assign owner  = r_owner;

endmodule
